// File: rtl/dma_program_sequencer_if.sv
// Opcode intake and register-write bus between the CPU decode stage, the
// program sequencer and the DMA controller.
interface dma_program_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int MOVE_W = 16
);
  logic              op_valid;
  logic              op_ready;
  logic [5:0]        op_code;
  logic [MOVE_W-1:0] move_data;
  logic [1:0]        op_channel;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  // Requester side: issues opcodes and accepts register writes.
  modport master (
    output op_valid, op_code, move_data, op_channel, wr_ready,
    input  op_ready, wr_valid, wr_addr, wr_data, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_code, move_data, op_channel, wr_ready,
    output op_ready, wr_valid, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/dma_program_sequencer.sv
// Expands one DMA opcode into an ordered burst of 8237 register writes,
// tracking a per-channel memory-source flag and flagging illegal requests.
module dma_program_sequencer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int MOVE_W  = 16,
  parameter int NUM_CH  = 4,
  parameter int IO_BASE = 32764,
  parameter int OPC_RAW = 56,
  parameter int OPC_SRC = 57,
  parameter int OPC_DST = 58
) (
  input  logic                    clk,
  input  logic                    rst,
  dma_program_sequencer_if.slave  bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEQ = 1'b1} state_t;
  typedef enum logic [2:0] {
    K_NONE    = 3'd0,
    K_RAW     = 3'd1,
    K_SRC_IO  = 3'd2,
    K_SRC_MEM = 3'd3,
    K_DST_MM  = 3'd4,
    K_DST_MI  = 3'd5,
    K_DST_SRC = 3'd6
  } kind_t;

  localparam logic [MOVE_W:0] LP_IO_BASE = (MOVE_W+1)'(IO_BASE);
  localparam logic [2:0]      LP_NUM_CH  = 3'(NUM_CH);

  function automatic logic [1:0] f_last(input kind_t k);
    logic [1:0] l;
    case (k)
      K_SRC_IO:  l = 2'd3;
      K_SRC_MEM: l = 2'd2;
      K_DST_MM:  l = 2'd2;
      K_DST_MI:  l = 2'd1;
      default:   l = 2'd0;
    endcase
    return l;
  endfunction

  function automatic logic [ADDR_W-1:0] f_step_addr(input kind_t k, input logic [1:0] idx,
                                                    input logic [1:0] ch);
    logic [4:0] a;
    a = 5'd0;
    case (k)
      K_RAW: a = 5'd1;
      K_SRC_IO: begin
        case (idx)
          2'd0:    a = 5'd7;
          2'd1:    a = 5'd11;
          2'd2:    a = 5'd10;
          default: a = 5'd12;
        endcase
      end
      K_SRC_MEM: begin
        case (idx)
          2'd0:    a = {2'b00, ch, 1'b0};
          2'd1:    a = 5'd11;
          default: a = 5'd12;
        endcase
      end
      K_DST_MM: begin
        case (idx)
          2'd0:    a = 5'd13;
          2'd1:    a = 5'd7;
          default: a = 5'd12;
        endcase
      end
      K_DST_MI:  a = (idx == 2'd0) ? 5'd10 : 5'd7;
      K_DST_SRC: a = {2'b00, ch, 1'b0};
      default:   a = 5'd0;
    endcase
    return ADDR_W'(a);
  endfunction

  function automatic logic [DATA_W-1:0] f_step_data(input kind_t k, input logic [1:0] idx,
                                                    input logic [1:0] ch,
                                                    input logic [MOVE_W-1:0] md);
    logic       use_md;
    logic [7:0] c;
    use_md = 1'b0;
    c      = 8'h00;
    case (k)
      K_RAW: use_md = 1'b1;
      K_SRC_IO: begin
        case (idx)
          2'd0:    c = 8'h80;
          2'd1:    c = {6'd0, ch};
          2'd2:    c = 8'h08 | {6'd0, ch};
          default: c = 8'h04 | {6'd0, ch};
        endcase
      end
      K_SRC_MEM: begin
        case (idx)
          2'd0:    use_md = 1'b1;
          2'd1:    c = {6'd0, ch};
          default: c = 8'h04 | {6'd0, ch};
        endcase
      end
      K_DST_MM: begin
        case (idx)
          2'd0:    use_md = 1'b1;
          2'd1:    c = 8'h01;
          default: c = 8'h04 | {6'd0, ch};
        endcase
      end
      K_DST_MI:  c = (idx == 2'd0) ? (8'h04 | {6'd0, ch}) : 8'h00;
      K_DST_SRC: use_md = 1'b1;
      default:   c = 8'h00;
    endcase
    return use_md ? DATA_W'(md) : DATA_W'(c);
  endfunction

  state_t            r_state;
  logic [1:0]        r_step;
  logic [1:0]        r_last;
  kind_t             r_kind;
  logic [1:0]        r_ch;
  logic [MOVE_W-1:0] r_md;
  logic [3:0]        r_mem_src;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_err;

  logic              w_accept;
  logic              w_is_io;
  logic              w_ch_ok;
  logic              w_illegal;
  kind_t             w_kind;
  logic [3:0]        w_mem_src_nxt;
  state_t            w_state_nxt;
  logic [1:0]        w_step_nxt;
  kind_t             w_sel_kind;
  logic [1:0]        w_sel_ch;
  logic [MOVE_W-1:0] w_sel_md;
  logic              w_nxt_wr_valid;
  logic [ADDR_W-1:0] w_nxt_wr_addr;
  logic [DATA_W-1:0] w_nxt_wr_data;
  logic              w_nxt_err;

  assign w_accept = bus.op_valid && (r_state == ST_IDLE);
  assign w_is_io  = {1'b0, bus.move_data} > LP_IO_BASE;
  assign w_ch_ok  = {1'b0, bus.op_channel} < LP_NUM_CH;

  // Classify the presented opcode and work out its effect on mem_src.
  always_comb begin
    w_kind        = K_NONE;
    w_illegal     = 1'b0;
    w_mem_src_nxt = r_mem_src;
    if (!w_ch_ok) begin
      w_illegal = 1'b1;
    end else if (bus.op_code == 6'(OPC_RAW)) begin
      w_kind = K_RAW;
    end else if (bus.op_code == 6'(OPC_SRC)) begin
      w_kind = w_is_io ? K_SRC_IO : K_SRC_MEM;
      w_mem_src_nxt[bus.op_channel] = !w_is_io;
    end else if (bus.op_code == 6'(OPC_DST)) begin
      if (r_mem_src[bus.op_channel]) begin
        w_kind = w_is_io ? K_DST_MI : K_DST_MM;
        w_mem_src_nxt[bus.op_channel] = 1'b0;
      end else if (w_is_io) begin
        w_illegal = 1'b1;
      end else begin
        w_kind = K_DST_SRC;
      end
    end else begin
      w_kind = K_NONE;
    end
  end

  // State register, step index and the operands latched at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_step    <= 2'd0;
      r_last    <= 2'd0;
      r_kind    <= K_NONE;
      r_ch      <= 2'd0;
      r_md      <= '0;
      r_mem_src <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      if (w_accept && !w_illegal) begin
        r_kind    <= w_kind;
        r_last    <= f_last(w_kind);
        r_ch      <= bus.op_channel;
        r_md      <= bus.move_data;
        r_mem_src <= w_mem_src_nxt;
      end
    end
  end

  // Next-state logic: IDLE -> SEQ on a productive accept, advance per write.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_illegal && (w_kind != K_NONE)) begin
          w_state_nxt = ST_SEQ;
          w_step_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEQ: begin
        if (bus.wr_ready && (r_step == r_last)) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = 2'd0;
        end else if (bus.wr_ready) begin
          w_step_nxt = r_step + 2'd1;
        end else begin
          w_step_nxt = r_step;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = 2'd0;
      end
    endcase
  end

  // Output decode: the write for the upcoming step, taken from the live
  // opcode while idle and from the latched copy once sequencing.
  always_comb begin
    w_sel_kind = (r_state == ST_IDLE) ? w_kind : r_kind;
    w_sel_ch   = (r_state == ST_IDLE) ? bus.op_channel : r_ch;
    w_sel_md   = (r_state == ST_IDLE) ? bus.move_data : r_md;
    w_nxt_err  = (r_state == ST_IDLE) && w_accept && w_illegal;
    if (w_state_nxt == ST_SEQ) begin
      w_nxt_wr_valid = 1'b1;
      w_nxt_wr_addr  = f_step_addr(w_sel_kind, w_step_nxt, w_sel_ch);
      w_nxt_wr_data  = f_step_data(w_sel_kind, w_step_nxt, w_sel_ch, w_sel_md);
    end else begin
      w_nxt_wr_valid = 1'b0;
      w_nxt_wr_addr  = '0;
      w_nxt_wr_data  = '0;
    end
  end

  // Registered write bus and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_valid <= w_nxt_wr_valid;
      r_wr_addr  <= w_nxt_wr_addr;
      r_wr_data  <= w_nxt_wr_data;
      r_err      <= w_nxt_err;
    end
  end

  assign bus.op_ready = (r_state == ST_IDLE) && !rst;
  assign bus.busy     = (r_state == ST_SEQ);
  assign bus.done     = (r_state == ST_SEQ) && r_wr_valid && bus.wr_ready && (r_step == r_last);
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_dma_program_sequencer.sv
// Scoreboard bench: expected writes are queued as opcodes are issued and
// matched against the write bus on each accepted handshake.
module tb_dma_program_sequencer;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dma_program_sequencer_if #(.DATA_W(32), .ADDR_W(8), .MOVE_W(16)) bus ();
  dma_program_sequencer_if #(.DATA_W(32), .ADDR_W(8), .MOVE_W(16)) bus2 ();

  dma_program_sequencer #(.NUM_CH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  dma_program_sequencer #(.NUM_CH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic push(input logic [7:0] a, input logic [31:0] d, input logic last);
    exp_t e;
    e.a = a; e.d = d; e.last = last;
    sb.push_back(e);
  endtask

  // Scoreboard: every accepted write must match the head of the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.wr_addr, bus.wr_data);
      end else begin
        e = sb.pop_front();
        if (bus.wr_addr !== e.a || bus.wr_data !== e.d || bus.done !== e.last) begin
          n_err++;
          $display("FAIL write_step: got addr=%0d data=%h done=%b, required addr=%0d data=%h done=%b",
                   bus.wr_addr, bus.wr_data, bus.done, e.a, e.d, e.last);
        end
      end
    end else if (bus.done === 1'b1) begin
      n_chk++; n_err++;
      $display("FAIL spurious_done: got done=1 without a write handshake, required 0");
    end
  end

  task automatic send_op(input logic [5:0] c, input logic [15:0] md, input logic [1:0] ch);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (bus.op_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_chk++;
    if (t >= 50) begin
      n_err++;
      $display("FAIL op_ready_timeout: got op_ready=%b after %0d cycles, required 1", bus.op_ready, t);
    end
    bus.op_valid = 1'b1; bus.op_code = c; bus.move_data = md; bus.op_channel = ch;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!(sb.size() == 0 && bus.busy === 1'b0) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    n_chk++;
    if (t >= 60) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d writes pending busy=%b, required 0 pending", name, sb.size(), bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_chk++;
    if ({bus.op_ready, bus.wr_valid, bus.busy, bus.done, bus.err} !== 5'b00000 ||
        bus.wr_addr !== 8'd0 || bus.wr_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b done=%b err=%b a=%0d d=%h, required all 0",
               bus.op_ready, bus.wr_valid, bus.busy, bus.done, bus.err, bus.wr_addr, bus.wr_data);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got op_ready=%b, required 1", bus.op_ready);
    end
  endtask

  task automatic test_raw();
    push(8'd1, 32'h0000_1234, 1'b1);
    send_op(6'd56, 16'h1234, 2'd0);
    n_chk++;
    if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 8'd1 || bus.wr_data !== 32'h1234 ||
        bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.op_ready !== 1'b0) begin
      n_err++;
      $display("FAIL raw_first_cycle: got v=%b a=%0d d=%h done=%b busy=%b rdy=%b, required 1 1 1234 1 1 0",
               bus.wr_valid, bus.wr_addr, bus.wr_data, bus.done, bus.busy, bus.op_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.op_ready !== 1'b1 || bus.wr_valid !== 1'b0 || bus.busy !== 1'b0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL raw_return_idle: got rdy=%b v=%b busy=%b pending=%0d, required 1 0 0 0",
               bus.op_ready, bus.wr_valid, bus.busy, sb.size());
    end
  endtask

  task automatic test_src_dst_mem();
    push(8'd4, 32'h100, 1'b0); push(8'd11, 32'd2, 1'b0); push(8'd12, 32'd6, 1'b1);
    send_op(6'd57, 16'h0100, 2'd2);
    wait_idle("src_mem");
    push(8'd13, 32'h200, 1'b0); push(8'd7, 32'd1, 1'b0); push(8'd12, 32'd6, 1'b1);
    send_op(6'd58, 16'h0200, 2'd2);
    wait_idle("dst_mem");
    // mem_src[2] must be clear again, so an IO destination is now illegal
    send_op(6'd58, 16'h9000, 2'd2);
    n_chk++;
    if (bus.err !== 1'b1 || bus.wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL memsrc2_cleared: got err=%b v=%b, required err=1 v=0", bus.err, bus.wr_valid);
    end
  endtask

  task automatic test_src_io_stall();
    push(8'd7, 32'h80, 1'b0); push(8'd11, 32'd1, 1'b0);
    push(8'd10, 32'h09, 1'b0); push(8'd12, 32'd5, 1'b1);
    send_op(6'd57, 16'h9000, 2'd1);
    @(posedge clk); #1;
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 8'd11 || bus.wr_data !== 32'd1) begin
        n_err++;
        $display("FAIL stall_stable: got v=%b a=%0d d=%h in stall cycle %0d, required 1 11 1",
                 bus.wr_valid, bus.wr_addr, bus.wr_data, i);
      end
    end
    bus.wr_ready = 1'b1;
    wait_idle("src_io_stall");
  endtask

  task automatic test_dst_io_err();
    send_op(6'd58, 16'h9000, 2'd0);
    n_chk++;
    if (bus.err !== 1'b1 || bus.wr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL io_to_io_err: got err=%b v=%b busy=%b rdy=%b, required 1 0 0 1",
               bus.err, bus.wr_valid, bus.busy, bus.op_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.err !== 1'b0 || bus.wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL err_one_cycle: got err=%b v=%b, required 0 0", bus.err, bus.wr_valid);
    end
  endtask

  task automatic test_illegal_channel();
    @(posedge clk); #1;
    bus2.op_valid = 1'b1; bus2.op_code = 6'd57; bus2.move_data = 16'h0100; bus2.op_channel = 2'd3;
    @(posedge clk); #1;
    bus2.op_valid = 1'b0;
    n_chk++;
    if (bus2.err !== 1'b1 || bus2.wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bad_channel_err: got err=%b v=%b, required 1 0", bus2.err, bus2.wr_valid);
    end
    bus2.op_valid = 1'b1; bus2.op_code = 6'd56; bus2.move_data = 16'h0055; bus2.op_channel = 2'd1;
    @(posedge clk); #1;
    bus2.op_valid = 1'b0;
    n_chk++;
    if (bus2.err !== 1'b0 || bus2.wr_valid !== 1'b1 || bus2.wr_addr !== 8'd1 ||
        bus2.wr_data !== 32'h55 || bus2.done !== 1'b1) begin
      n_err++;
      $display("FAIL good_channel_raw: got err=%b v=%b a=%0d d=%h done=%b, required 0 1 1 55 1",
               bus2.err, bus2.wr_valid, bus2.wr_addr, bus2.wr_data, bus2.done);
    end
  endtask

  task automatic test_boundary();
    push(8'd6, 32'd32764, 1'b0); push(8'd11, 32'd3, 1'b0); push(8'd12, 32'd7, 1'b1);
    send_op(6'd57, 16'd32764, 2'd3);
    wait_idle("boundary_mem");
    push(8'd7, 32'h80, 1'b0); push(8'd11, 32'd3, 1'b0);
    push(8'd10, 32'h0B, 1'b0); push(8'd12, 32'd7, 1'b1);
    send_op(6'd57, 16'd32765, 2'd3);
    wait_idle("boundary_io");
  endtask

  task automatic test_dst_paths();
    push(8'd0, 32'h50, 1'b0); push(8'd11, 32'd0, 1'b0); push(8'd12, 32'd4, 1'b1);
    send_op(6'd57, 16'h0050, 2'd0);
    wait_idle("src_mem_ch0");
    push(8'd10, 32'd4, 1'b0); push(8'd7, 32'd0, 1'b1);
    send_op(6'd58, 16'h9000, 2'd0);
    wait_idle("dst_mem_to_io");
    push(8'd2, 32'h400, 1'b1);
    send_op(6'd58, 16'h0400, 2'd1);
    wait_idle("dst_as_src");
    send_op(6'd5, 16'h1111, 2'd0);
    n_chk++;
    if (bus.err !== 1'b0 || bus.wr_valid !== 1'b0 || bus.op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL other_opcode_ignored: got err=%b v=%b rdy=%b, required 0 0 1",
               bus.err, bus.wr_valid, bus.op_ready);
    end
  endtask

  task automatic test_reset_mid();
    push(8'd4, 32'h300, 1'b0); push(8'd11, 32'd2, 1'b0); push(8'd12, 32'd6, 1'b1);
    send_op(6'd57, 16'h0300, 2'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.wr_addr !== 8'd12 || sb.size() != 1) begin
      n_err++;
      $display("FAIL mid_seq_position: got a=%0d pending=%0d, required a=12 pending=1", bus.wr_addr, sb.size());
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.wr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: got v=%b busy=%b rdy=%b, required 0 0 0", bus.wr_valid, bus.busy, bus.op_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_abort_ready: got op_ready=%b, required 1", bus.op_ready);
    end
    send_op(6'd58, 16'h9000, 2'd2);
    n_chk++;
    if (bus.err !== 1'b1 || bus.wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_clears_memsrc: got err=%b v=%b, required 1 0", bus.err, bus.wr_valid);
    end
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_code = 6'd0; bus.move_data = 16'd0; bus.op_channel = 2'd0;
    bus.wr_ready = 1'b1;
    bus2.op_valid = 1'b0; bus2.op_code = 6'd0; bus2.move_data = 16'd0; bus2.op_channel = 2'd0;
    bus2.wr_ready = 1'b1;
    test_reset();
    test_raw();
    test_src_dst_mem();
    test_src_io_stall();
    test_dst_io_err();
    test_illegal_channel();
    test_boundary();
    test_dst_paths();
    test_reset_mid();
    @(posedge clk); #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drained: got %0d pending writes, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_program_sequencer.md
Name: dma_program_sequencer

Overview:
Parametrised multi-channel successor to the single-channel DMA register programmer. It accepts one DMA opcode per handshake from the CPU decode stage and expands it into an ordered burst of register writes to an 8237-style DMA controller. Writes leave on a valid/ready bus, so a stalling controller is tolerated. Source type (memory or IO) is tracked per channel, and illegal requests are flagged.

Parameters:
DATA_W, 32, width of wr_data
ADDR_W, 8, width of wr_addr (must be >= 5)
MOVE_W, 16, width of move_data (must be <= DATA_W)
NUM_CH, 4, number of DMA channels (1..4)
IO_BASE, 32764, move_data values above this are IO addresses; values at or below it are memory
OPC_RAW, 56, opcode for a raw write to register 1
OPC_SRC, 57, opcode that programs the transfer source
OPC_DST, 58, opcode that programs the transfer destination

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  asynchronous, active-high reset
op_valid  in  1  an opcode is presented
op_ready  out  1  sequencer can accept an opcode
op_code  in  6  opcode
move_data  in  MOVE_W  address or data operand
op_channel  in  2  target channel
wr_valid  out  1  a register write is presented
wr_ready  in  1  DMA controller accepts the write
wr_addr  out  ADDR_W  DMA register address
wr_data  out  DATA_W  DMA register data
busy  out  1  a sequence is in progress
done  out  1  one-cycle pulse when the last write of a sequence is accepted
err  out  1  one-cycle pulse when an illegal opcode request is dropped

Behaviour:
- Reset (asynchronous): state=IDLE; mem_src[NUM_CH-1:0]=0; all outputs 0, including op_ready. After reset deasserts, op_ready=1 while in IDLE.
- Register map: SRC_BASE(ch)=2*ch; CMD=7; MODE=10; MASK=11; REQ=12; DST_BASE=13; RAW=1.
- Per-channel data fields: MASKCLR=ch; REQSET=0x04|ch; MODE_RD=0x08|ch; MODE_WR=0x04|ch. wr_data is move_data zero-extended to DATA_W, or one of these constants zero-extended.
- Accept rule: an opcode is accepted on a rising edge with op_valid && op_ready. op_ready = (state==IDLE). On accept, latch op_code, move_data and op_channel, and classify the request. "io" means move_data > IO_BASE; the value == IO_BASE counts as memory.
- Step lists, emitted in this order:
  - RAW: (1, move_data).
  - SRC with io: (CMD,0x80), (MASK,MASKCLR), (MODE,MODE_RD), (REQ,REQSET). Clears mem_src[ch].
  - SRC with memory: (SRC_BASE(ch),move_data), (MASK,MASKCLR), (REQ,REQSET). Sets mem_src[ch].
  - DST with mem_src[ch]=1 and memory: (DST_BASE,move_data), (CMD,0x01), (REQ,REQSET). Clears mem_src[ch].
  - DST with mem_src[ch]=1 and io: (MODE,MODE_WR), (CMD,0x00). Clears mem_src[ch].
  - DST with mem_src[ch]=0 and memory: (SRC_BASE(ch),move_data).
- Illegal requests:
  - DST with mem_src[ch]=0 and io (IO to IO) → err.
  - op_channel >= NUM_CH, for any opcode → err.
  - On err: pulse err for one cycle in the cycle after accept, emit no writes, and stay in IDLE.
- Other opcodes: accepted and ignored, with no writes and no pulses.
- mem_src is updated at the accept edge.
- States: IDLE → SEQ(step index 0..3) → IDLE.
  - Cycle after accept: wr_valid=1 with step 0 and busy=1.
  - wr_addr and wr_data stay stable while wr_valid && !wr_ready.
  - On each accepted write the index advances.
  - On acceptance of the last step: done=1 for that cycle, and the state returns to IDLE, so op_ready=1 on the next cycle.
  - With wr_ready tied high, a k-step opcode occupies k+1 cycles including the accept cycle.
- Reset mid-sequence: the sequence aborts immediately, wr_valid drops, and mem_src is cleared.
- Channels are independent: mem_src of other channels is never modified.

Test Plan:
- Reset, then op 56 with move_data=0x1234 and wr_ready=1 → one write (1,0x00001234) one cycle after accept, done in the same cycle, op_ready high on the next cycle.
- op 57 with ch=2 and move_data=0x0100, then op 58 with ch=2 and move_data=0x0200 → writes (4,0x100), (11,2), (12,6), then (13,0x200), (7,1), (12,6); mem_src[2] returns to 0.
- op 57 with ch=1 and move_data=0x9000 → writes (7,0x80), (11,1), (10,0x09), (12,5). Hold wr_ready=0 for 3 cycles on step 1 → address and data stay stable and no step is lost.
- op 58 with ch=0, mem_src[0]=0 and move_data=0x9000 → err pulse, no wr_valid. Then op 57 with op_channel=3 under NUM_CH=2 → err pulse.
- Boundary: op 57 with move_data=32764 → memory path (SRC_BASE write). move_data=32765 → IO path.
- Assert rst during step 2 of an op-57 memory sequence → wr_valid=0 immediately, mem_src=0, op_ready=1 after release.
